// File: rtl/mem_region_decoder.sv
// Decodes one master memory port onto N_REGIONS ascending-base sub-memories and
// steers read data back through a RD_LATENCY-deep tag pipeline; counts out-of-range accesses.
module mem_region_decoder #(
  parameter int                          DATA_W      = 8,
  parameter int                          ADDR_W      = 8,
  parameter int                          N_REGIONS   = 3,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {8'h80, 8'h40, 8'h10},
  parameter int                          RD_LATENCY  = 1,
  parameter logic [DATA_W-1:0]           ERR_DATA    = 8'hFF,
  parameter int                          CNT_W       = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Cs,
  input  logic                          Wen,
  input  logic                          Oen,
  input  logic [ADDR_W-1:0]             Address,
  input  logic [DATA_W-1:0]             DataIn,
  output logic [DATA_W-1:0]             DataOut,
  output logic                          DataValid,
  output logic                          AddrErr,
  output logic [CNT_W-1:0]              ErrCnt,
  input  logic                          ErrCntClr,
  output logic [N_REGIONS-1:0]          RegCs,
  output logic                          RegWen,
  output logic                          RegOen,
  output logic [ADDR_W-1:0]             RegAddress,
  output logic [DATA_W-1:0]             RegDataIn,
  input  logic [N_REGIONS*DATA_W-1:0]   RegDataOut
);

  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  function automatic logic [ADDR_W-1:0] base_of(input int i);
    return REGION_BASE[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [N_REGIONS-1:0] ge;
  logic [N_REGIONS-1:0] hit;
  logic [IDX_W-1:0]     hit_idx;
  logic                 miss;
  logic                 rd_req;

  // Bases ascend, so the hit region is the highest one whose base is <= Address.
  always_comb begin
    ge      = '0;
    hit_idx = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      ge[i] = (Address >= base_of(i));
      if (ge[i]) hit_idx = IDX_W'(i);
    end
    hit  = ge & ~(ge >> 1);
    miss = ~ge[0];
  end

  assign rd_req     = Cs & ~Wen & Oen;
  assign RegCs      = {N_REGIONS{Cs}} & hit;
  assign RegAddress = miss ? '0 : Address - base_of(int'(hit_idx));
  assign RegWen     = Wen;
  assign RegOen     = Oen;
  assign RegDataIn  = DataIn;

  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_err_q;
  logic [IDX_W-1:0]      tag_idx_q [RD_LATENCY];
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic                  sel_err_q, sel_err_d;
  logic                  wmiss_q, wmiss_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic                  ex_vld, ex_err;
  logic [IDX_W-1:0]      ex_idx;
  logic [1:0]            err_inc;

  assign ex_vld = tag_vld_q[RD_LATENCY-1];
  assign ex_err = tag_err_q[RD_LATENCY-1];
  assign ex_idx = tag_idx_q[RD_LATENCY-1];

  // The exiting tag wins the data mux; otherwise the last completed read's source is held.
  always_comb begin
    sel_idx_d = ex_vld ? ex_idx : sel_idx_q;
    sel_err_d = ex_vld ? ex_err : sel_err_q;
    DataOut   = ERR_DATA;
    if (!sel_err_d && int'(sel_idx_d) < N_REGIONS)
      DataOut = RegDataOut[int'(sel_idx_d)*DATA_W +: DATA_W];
    wmiss_d   = Cs & Wen & miss;
    err_inc   = {1'b0, ex_vld & ex_err} + {1'b0, wmiss_q};
    err_cnt_d = ErrCntClr ? '0 : sat_add(err_cnt_q, err_inc);
  end

  assign DataValid = ex_vld;
  assign AddrErr   = (ex_vld & ex_err) | wmiss_q;
  assign ErrCnt    = err_cnt_q;

  // ---- tag pipeline / control state ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tag_vld_q <= '0;
      sel_idx_q <= '0;
      sel_err_q <= 1'b0;
      wmiss_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      for (int k = RD_LATENCY-1; k > 0; k--) tag_vld_q[k] <= tag_vld_q[k-1];
      tag_vld_q[0] <= rd_req;
      sel_idx_q    <= sel_idx_d;
      sel_err_q    <= sel_err_d;
      wmiss_q      <= wmiss_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // ---- tag payload, qualified by tag_vld_q ----
  always_ff @(posedge Clk) begin
    for (int k = RD_LATENCY-1; k > 0; k--) begin
      tag_idx_q[k] <= tag_idx_q[k-1];
      tag_err_q[k] <= tag_err_q[k-1];
    end
    tag_idx_q[0] <= hit_idx;
    tag_err_q[0] <= miss;
  end

endmodule

// File: tb/tb_mem_region_decoder.sv
// Bench for mem_region_decoder: three instances (latency 1/3/2, counter widths 8/2/8)
// share one stimulus stream and are compared each cycle against an address-map model.
module tb_mem_region_decoder;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst, Cs, Wen, Oen, ErrCntClr;
  logic [7:0]  Address, DataIn;
  logic [23:0] rdo   [3];
  logic [7:0]  dout  [3];
  logic        dval  [3];
  logic        aerr  [3];
  logic [2:0]  rcs   [3];
  logic        rwen  [3];
  logic        roen  [3];
  logic [7:0]  raddr [3];
  logic [7:0]  rdin  [3];
  logic [7:0]  ec0, ec2;
  logic [1:0]  ec1;

  mem_region_decoder u_a (
    .Clk(Clk), .Rst(Rst), .Cs(Cs), .Wen(Wen), .Oen(Oen), .Address(Address), .DataIn(DataIn),
    .DataOut(dout[0]), .DataValid(dval[0]), .AddrErr(aerr[0]), .ErrCnt(ec0), .ErrCntClr(ErrCntClr),
    .RegCs(rcs[0]), .RegWen(rwen[0]), .RegOen(roen[0]), .RegAddress(raddr[0]),
    .RegDataIn(rdin[0]), .RegDataOut(rdo[0])
  );

  mem_region_decoder #(.RD_LATENCY(3), .CNT_W(2)) u_b (
    .Clk(Clk), .Rst(Rst), .Cs(Cs), .Wen(Wen), .Oen(Oen), .Address(Address), .DataIn(DataIn),
    .DataOut(dout[1]), .DataValid(dval[1]), .AddrErr(aerr[1]), .ErrCnt(ec1), .ErrCntClr(ErrCntClr),
    .RegCs(rcs[1]), .RegWen(rwen[1]), .RegOen(roen[1]), .RegAddress(raddr[1]),
    .RegDataIn(rdin[1]), .RegDataOut(rdo[1])
  );

  mem_region_decoder #(.RD_LATENCY(2)) u_c (
    .Clk(Clk), .Rst(Rst), .Cs(Cs), .Wen(Wen), .Oen(Oen), .Address(Address), .DataIn(DataIn),
    .DataOut(dout[2]), .DataValid(dval[2]), .AddrErr(aerr[2]), .ErrCnt(ec2), .ErrCntClr(ErrCntClr),
    .RegCs(rcs[2]), .RegWen(rwen[2]), .RegOen(roen[2]), .RegAddress(raddr[2]),
    .RegDataIn(rdin[2]), .RegDataOut(rdo[2])
  );

  localparam int LAT  [3] = '{1, 3, 2};
  localparam int CMAX [3] = '{255, 3, 255};
  localparam int BASE [3] = '{16, 64, 128};

  // Reads due in a given cycle, held in a ring indexed by completion cycle.
  bit pv   [3][8];
  int pidx [3][8];
  bit perr [3][8];
  int sel  [3];
  int cnt  [3];
  bit wm   [3];
  int cyc;
  int checks;
  int errors;

  function automatic int region_of(input int a);
    int r;
    r = -1;
    for (int i = 0; i < 3; i++) if (a >= BASE[i]) r = i;
    return r;
  endfunction

  function automatic int ecnt_of(input int d);
    case (d)
      0:       return int'(ec0);
      1:       return int'(ec1);
      default: return int'(ec2);
    endcase
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit cs, input bit we, input bit oe, input int a, input bit clr);
    int reg_i, slot, s2, eidx, exp_do, exp_cs, exp_ra, n;
    bit ev, eerr;
    Rst = r; Cs = cs; Wen = we; Oen = oe; Address = 8'(a); ErrCntClr = clr;
    DataIn = 8'($urandom);
    for (int d = 0; d < 3; d++) rdo[d] = 24'($urandom);
    #1;
    reg_i = region_of(a);
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        for (int k = 0; k < 8; k++) pv[d][k] = 1'b0;
        sel[d] = 0; cnt[d] = 0; wm[d] = 1'b0;
      end
      slot = cyc % 8;
      ev   = pv[d][slot];
      eidx = pidx[d][slot];
      eerr = perr[d][slot];
      if (ev) exp_do = eerr ? 255 : (int'(rdo[d]) >> (8*eidx)) & 255;
      else    exp_do = (sel[d] < 0) ? 255 : (int'(rdo[d]) >> (8*sel[d])) & 255;
      exp_cs = (cs && reg_i >= 0) ? (1 << reg_i) : 0;
      exp_ra = (reg_i >= 0) ? a - BASE[reg_i] : 0;
      chk("DataValid",  d, 32'(dval[d]),  32'(ev));
      chk("AddrErr",    d, 32'(aerr[d]),  32'((ev && eerr) || wm[d]));
      chk("DataOut",    d, 32'(dout[d]),  32'(exp_do));
      chk("ErrCnt",     d, 32'(ecnt_of(d)), 32'(cnt[d]));
      chk("RegCs",      d, 32'(rcs[d]),   32'(exp_cs));
      chk("RegAddress", d, 32'(raddr[d]), 32'(exp_ra));
      chk("PassThru",   d, 32'({rwen[d], roen[d], rdin[d]}), 32'({we, oe, DataIn}));
      if (!r) begin
        if (ev) begin
          sel[d] = eerr ? -1 : eidx;
          pv[d][slot] = 1'b0;
        end
        n = ((ev && eerr) ? 1 : 0) + (wm[d] ? 1 : 0);
        cnt[d] = clr ? 0 : ((cnt[d] + n > CMAX[d]) ? CMAX[d] : cnt[d] + n);
        wm[d]  = cs && we && (reg_i < 0);
        if (cs && !we && oe) begin
          s2 = (cyc + LAT[d]) % 8;
          pv[d][s2]   = 1'b1;
          pidx[d][s2] = reg_i;
          perr[d][s2] = (reg_i < 0);
        end
      end
    end
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom_range(0, 255), 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    Rst = 1'b0; Cs = 1'b0; Wen = 1'b0; Oen = 1'b0; ErrCntClr = 1'b0;
    Address = '0; DataIn = '0;
    for (int d = 0; d < 3; d++) begin
      rdo[d] = '0; sel[d] = 0; cnt[d] = 0; wm[d] = 1'b0;
      for (int k = 0; k < 8; k++) begin pv[d][k] = 1'b0; pidx[d][k] = 0; perr[d][k] = 1'b0; end
    end

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(1);
    // basic read in region 0
    step(0, 1, 0, 1, 8'h10, 0);
    idle(4);
    // region boundaries
    step(0, 1, 1, 0, 8'h3F, 0);
    step(0, 1, 1, 0, 8'h40, 0);
    step(0, 1, 1, 0, 8'h7F, 0);
    step(0, 1, 1, 0, 8'h80, 0);
    step(0, 1, 1, 0, 8'hFF, 0);
    step(0, 1, 1, 0, 8'h0F, 0);
    idle(2);
    // back-to-back reads across all regions, then hold
    step(0, 1, 0, 1, 8'h20, 0);
    step(0, 1, 0, 1, 8'h50, 0);
    step(0, 1, 0, 1, 8'h90, 0);
    idle(5);
    // read miss then write miss; on the latency-3 instance their errors coincide
    step(0, 1, 0, 1, 8'h05, 0);
    idle(1);
    step(0, 1, 1, 0, 8'h00, 0);
    idle(4);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'h00, 0);
    idle(2);
    step(0, 1, 1, 0, 8'h03, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    idle(3);
    // write priority over read
    step(0, 1, 1, 1, 8'h40, 0);
    idle(4);
    // reset with reads in flight
    step(0, 1, 0, 1, 8'h50, 0);
    step(0, 1, 0, 1, 8'h02, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    idle(5);
    // Cs low suppresses selects and tags
    step(0, 0, 0, 1, 8'h45, 0);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, a, $urandom_range(0, 24) == 0);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
